// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer: FSM state codes and a sizing helper.
package rst_pkg;

    // FSM state encoding (2 bits)
    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_REL  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Larger of two non-negative integers; sizes the shared hold/gap counter
    function automatic int max_u(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Flop chain that brings an asynchronous level into the clk_sys domain.
// A synchronous active-low clear empties the whole chain.
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the input one stage deeper every cycle
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Chain register with synchronous clear
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_n_seq.sv
// Reset sequencer: holds every reset domain low for MIN_ASSERT cycles after all
// reset sources go quiet, then releases the domains one by one, RELEASE_GAP
// cycles apart, bit 0 first. A synchronised soft request aborts and restarts
// the sequence from any point.
//
// Handshake: there is no valid/ready pair here. soft_rst_req is a level that the
// requester must hold for at least SYNC_STAGES+1 cycles; rst_done is a level
// that is 1 exactly while the FSM is in RUN.
module rst_n_seq
    import rst_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ASSERT  = 16,
    parameter int RELEASE_GAP = 8
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               rst_done,
    output logic               rst_cause,
    output logic [1:0]         dbg_state
);

    localparam int CNT_MAX = max_u(MIN_ASSERT, RELEASE_GAP);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic                req_s;
    logic [1:0]          state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [NUM_OUT-1:0]  rst_out_n_q, rst_out_n_d;
    logic                rst_done_q,  rst_done_d;
    logic                rst_cause_q, rst_cause_d;

    rst_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .d       (soft_rst_req),
        .q       (req_s)
    );

    // State, counters and output registers; rst_n forces the held-in-reset values
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_out_n_q <= '0;
            rst_done_q  <= 1'b0;
            rst_cause_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_out_n_q <= rst_out_n_d;
            rst_done_q  <= rst_done_d;
            rst_cause_q <= rst_cause_d;
        end
    end

    // Next-state logic: a soft request always returns to HOLD; HOLD itself
    // just keeps waiting while the request stays high
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HOLD: begin
                if (!req_s && cnt_q == HOLD_LAST) begin
                    state_d = (NUM_OUT == 1) ? ST_RUN : ST_REL;
                end
            end
            ST_REL: begin
                if (req_s) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == GAP_LAST && idx_q == IDX_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (req_s) begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // Output/datapath logic: counter, release index and the registered reset bits
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rst_out_n_d = rst_out_n_q;
        rst_done_d  = rst_done_q;
        rst_cause_d = rst_cause_q;
        unique case (state_q)
            ST_HOLD: begin
                rst_out_n_d = '0;
                rst_done_d  = 1'b0;
                if (req_s) begin
                    // hold time restarts only once the request has gone away
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d       = '0;
                    rst_out_n_d = NUM_OUT'(1);
                    idx_d       = IDX_ONE;
                    rst_done_d  = (NUM_OUT == 1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REL: begin
                if (req_s) begin
                    // abort: already released channels drop back into reset
                    rst_out_n_d = '0;
                    rst_done_d  = 1'b0;
                    cnt_d       = '0;
                    idx_d       = '0;
                    rst_cause_d = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_out_n_d[i] = 1'b1;
                        end
                    end
                    idx_d      = idx_q + IDX_ONE;
                    cnt_d      = '0;
                    rst_done_d = (idx_q == IDX_LAST);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (req_s) begin
                    rst_out_n_d = '0;
                    rst_done_d  = 1'b0;
                    cnt_d       = '0;
                    idx_d       = '0;
                    rst_cause_d = 1'b1;
                end
            end
            default: begin
                rst_out_n_d = '0;
                rst_done_d  = 1'b0;
                cnt_d       = '0;
                idx_d       = '0;
            end
        endcase
    end

    assign rst_out_n = rst_out_n_q;
    assign rst_done  = rst_done_q;
    assign rst_cause = rst_cause_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rst_n_seq.sv
// Bench for rst_n_seq: directed timing checks plus a randomised phase, all
// cycles checked by a scoreboard fed from a time-based reference model.
module tb_rst_n_seq;

    localparam int N    = 4;
    localparam int S    = 2;
    localparam int MIN  = 16;
    localparam int GAP  = 8;
    localparam int TSAT = 100000;
    localparam int W    = N + 2;

    logic         clk_sys = 1'b0;
    logic         rst_n = 1'b0;
    logic         soft_rst_req = 1'b0;
    logic [N-1:0] rst_out_n;
    logic         rst_done;
    logic         rst_cause;
    logic [1:0]   dbg_state;

    logic         soft2 = 1'b0;
    logic [0:0]   rst_out_n2;
    logic         rst_done2;
    logic         rst_cause2;
    logic [1:0]   dbg_state2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk_sys = ~clk_sys;

    rst_n_seq #(.NUM_OUT(N), .SYNC_STAGES(S), .MIN_ASSERT(MIN), .RELEASE_GAP(GAP)) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .soft_rst_req (soft_rst_req),
        .rst_out_n    (rst_out_n),
        .rst_done     (rst_done),
        .rst_cause    (rst_cause),
        .dbg_state    (dbg_state)
    );

    rst_n_seq #(.NUM_OUT(1), .SYNC_STAGES(2), .MIN_ASSERT(1), .RELEASE_GAP(1)) dut_min (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .soft_rst_req (soft2),
        .rst_out_n    (rst_out_n2),
        .rst_done     (rst_done2),
        .rst_cause    (rst_cause2),
        .dbg_state    (dbg_state2)
    );

    // ---------------- reference model ----------------
    // t = clock edges of quiet (rst_n high, synchronised request low) since the
    // last reset entry; channel i is released once t >= MIN + i*GAP.
    int           m_t = 0;
    logic         m_cause = 1'b0;
    logic [S-1:0] m_hist = '0;

    always @(posedge clk_sys) begin
        logic         req_seen;
        logic [N-1:0] e_out;
        if (!rst_n) begin
            m_hist  = '0;
            m_t     = 0;
            m_cause = 1'b0;
        end else begin
            req_seen = m_hist[S-1];
            if (req_seen) begin
                if (m_t >= MIN) m_cause = 1'b1;
                m_t = 0;
            end else if (m_t < TSAT) begin
                m_t = m_t + 1;
            end
            m_hist = {m_hist[S-2:0], soft_rst_req};
        end
        for (int i = 0; i < N; i++) e_out[i] = (m_t >= MIN + i * GAP);
        exp_q.push_back({m_cause, e_out[N-1], e_out});
    end

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk_sys) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        #1;
        act_v = {rst_cause, rst_done, rst_out_n};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %b, required an expected entry", act_v);
        end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL sb @%0t: {cause,done,out}=%b required %b", $time, act_v, exp_v);
            end
        end
        n_checks++;
        for (int i = 1; i < N; i++) begin
            if (rst_out_n[i] && !rst_out_n[i-1]) begin
                n_fail++;
                $display("FAIL monotonic @%0t: rst_out_n=%b required bit %0d clear", $time, rst_out_n, i);
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_out(input logic [N-1:0] want, input int budget, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge clk_sys);
            #1;
            if (rst_out_n === want) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: rst_out_n=%b required %b within %0d cycles", name, rst_out_n, want, budget);
        end
    endtask

    // rst_n is assumed to have just risen at a negedge; edge 1 is the next posedge
    task automatic release_checks(input bit check_min);
        int           edge_tab[8] = '{15, 16, 23, 24, 31, 32, 39, 40};
        logic [N-1:0] out_tab[8]  = '{4'b0000, 4'b0001, 4'b0001, 4'b0011,
                                      4'b0011, 4'b0111, 4'b0111, 4'b1111};
        logic         done_tab[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_sys);
            #1;
            if (check_min && k == 1) begin
                check("min_out_edge1", 32'(rst_out_n2), 32'd1);
                check("min_done_edge1", 32'(rst_done2), 32'd1);
            end
            for (int j = 0; j < 8; j++) begin
                if (edge_tab[j] == k) begin
                    check($sformatf("out_edge%0d", k), 32'(rst_out_n), 32'(out_tab[j]));
                    check($sformatf("done_edge%0d", k), 32'(rst_done), 32'(done_tab[j]));
                end
            end
        end
        check("cause_after_por", 32'(rst_cause), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1: power-on reset
        rst_n = 1'b0;
        soft_rst_req = 1'b0;
        cycles(5);
        check("reset_out", 32'(rst_out_n), 32'd0);
        check("reset_done", 32'(rst_done), 32'd0);
        check("reset_cause", 32'(rst_cause), 32'd0);
        check("reset_min_out", 32'(rst_out_n2), 32'd0);
        rst_n = 1'b1;
        release_checks(1'b1);

        // 2: soft request in RUN for 10 cycles
        cycles(5);
        soft_rst_req = 1'b1;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        check("soft_edge2_out", 32'(rst_out_n), 32'hF);
        @(posedge clk_sys); #1;
        check("soft_edge3_out", 32'(rst_out_n), 32'd0);
        check("soft_edge3_done", 32'(rst_done), 32'd0);
        check("soft_edge3_cause", 32'(rst_cause), 32'd1);
        cycles(7);
        soft_rst_req = 1'b0;
        wait_out(4'b1111, 60, "soft_rerelease");

        // 3: soft request mid-REL with 0011 released
        cycles(3);
        soft_rst_req = 1'b1;
        wait_out(4'b0000, 10, "hold_again");
        cycles(2);
        soft_rst_req = 1'b0;
        wait_out(4'b0011, 60, "reach_0011");
        @(negedge clk_sys);
        soft_rst_req = 1'b1;
        repeat (3) begin @(posedge clk_sys); #1; end
        check("abort_rel_out", 32'(rst_out_n), 32'd0);
        check("abort_rel_cause", 32'(rst_cause), 32'd1);
        cycles(2);
        soft_rst_req = 1'b0;
        wait_out(4'b0011, 60, "restart_0011");

        // 4: one-cycle rst_n pulse mid-REL
        @(negedge clk_sys);
        rst_n = 1'b0;
        @(posedge clk_sys); #1;
        check("por_mid_out", 32'(rst_out_n), 32'd0);
        check("por_mid_cause", 32'(rst_cause), 32'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        release_checks(1'b0);

        // 5: rst_n and soft request together
        @(negedge clk_sys);
        rst_n = 1'b0;
        soft_rst_req = 1'b1;
        cycles(4);
        rst_n = 1'b1;
        cycles(5);
        check("both_out", 32'(rst_out_n), 32'd0);
        check("both_cause", 32'(rst_cause), 32'd0);
        soft_rst_req = 1'b0;
        wait_out(4'b0001, 30, "both_release");
        check("both_cause_rel", 32'(rst_cause), 32'd0);

        // random phase: idle gaps, soft pulses, rst_n pulses
        for (int it = 0; it < 30; it++) begin
            cycles($urandom_range(1, 60));
            if ($urandom_range(0, 3) == 0) begin
                rst_n = 1'b0;
                if ($urandom_range(0, 1) == 1) soft_rst_req = 1'b1;
                cycles($urandom_range(1, 3));
                rst_n = 1'b1;
                cycles($urandom_range(0, 4));
                soft_rst_req = 1'b0;
            end else begin
                soft_rst_req = 1'b1;
                cycles($urandom_range(S + 1, 12));
                soft_rst_req = 1'b0;
            end
        end
        cycles(80);
        check("final_done", 32'(rst_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
